// File: rtl/reset_release_seq_if.sv
// rtl/reset_release_seq_if.sv - control/status bundle between the reset sequencer and its domains
interface reset_release_seq_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                           delay_done_i;
  logic                           sw_rst_req_i;
  logic [NUM_DOMAINS-1:0]         dom_ack_i;
  logic [NUM_DOMAINS-1:0]         dom_rst_n_o;
  logic                           all_ready_o;
  logic                           busy_o;
  logic                           err_o;
  logic [$clog2(NUM_DOMAINS):0]   err_dom_o;

  // Sequencer side
  modport master (
    input  delay_done_i, sw_rst_req_i, dom_ack_i,
    output dom_rst_n_o, all_ready_o, busy_o, err_o, err_dom_o
  );

  // Domain / supervisor side
  modport slave (
    output delay_done_i, sw_rst_req_i, dom_ack_i,
    input  dom_rst_n_o, all_ready_o, busy_o, err_o, err_dom_o
  );
endinterface

// File: rtl/reset_release_seq.sv
// rtl/reset_release_seq.sv - ordered domain reset release/re-assert sequencer (optional ack gating: RST_SEQ_ACK_EN)
module reset_release_seq #(
  parameter int NUM_DOMAINS = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 256
) (
  input logic                  clk,
  input logic                  rst,
  reset_release_seq_if.master  bus
);

  localparam int IW   = $clog2(NUM_DOMAINS) + 1;
  localparam int CMAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;
  localparam logic [IW-1:0] LAST     = IW'(NUM_DOMAINS - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CMAX);
  localparam logic [CW-1:0] GAP_C    = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifdef RST_SEQ_ACK_EN
  localparam logic [CW-1:0] TO_LAST  = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_RELEASE, S_WAIT_ACK, S_GAP, S_DONE, S_ASSERT_SEQ, S_ERROR
  } state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;
  logic [NUM_DOMAINS-1:0] dom_q, dom_nxt, sel, abort_sel;
  logic                   ready_q, ready_nxt;
  logic                   busy_q, busy_nxt;
  logic                   err_q, err_nxt;
  logic [IW-1:0]          err_dom_q, err_dom_nxt;
  logic                   sync1, done_s;
  logic                   adv, next_dom, do_abort;
  logic [IW-1:0]          abort_idx;

`ifndef RST_SEQ_ACK_EN
  logic unused_ack;
  assign unused_ack = ^bus.dom_ack_i;
`endif

  // Two-flop synchroniser for the asynchronous delay-generator done level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      done_s <= 1'b0;
    end else begin
      sync1  <= bus.delay_done_i;
      done_s <= sync1;
    end
  end

  assign sel     = NUM_DOMAINS'(1) << idx;
  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);

  // Next-state and next-output decode; outputs are registered alongside the state
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    dom_nxt     = dom_q;
    ready_nxt   = (state == S_DONE);
    busy_nxt    = (state inside {S_RELEASE, S_WAIT_ACK, S_GAP, S_ASSERT_SEQ});
    err_nxt     = err_q;
    err_dom_nxt = err_dom_q;
    adv         = 1'b0;
    next_dom    = 1'b0;
    do_abort    = 1'b0;
    abort_idx   = idx;
    abort_sel   = '0;

    if (!done_s && state != S_IDLE && state != S_ERROR) begin
      // Losing the upstream done level drops every domain at once
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
      dom_nxt   = '0;
      ready_nxt = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          dom_nxt = '0;
          if (done_s && !bus.sw_rst_req_i) begin
            state_nxt = S_RELEASE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
          end
        end
        S_RELEASE: begin
          if (bus.sw_rst_req_i) begin
            do_abort = 1'b1;
          end else begin
            dom_nxt = dom_q | sel;
`ifdef RST_SEQ_ACK_EN
            state_nxt = S_WAIT_ACK;
            cnt_nxt   = '0;
`else
            adv = 1'b1;
`endif
          end
        end
`ifdef RST_SEQ_ACK_EN
        S_WAIT_ACK: begin
          if (cnt >= TO_LAST) begin
            state_nxt   = S_ERROR;
            err_nxt     = 1'b1;
            err_dom_nxt = idx;
          end else if (bus.sw_rst_req_i) begin
            do_abort = 1'b1;
          end else if (|(bus.dom_ack_i & sel)) begin
            adv = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_ERROR: begin
          dom_nxt = '0;
          if (bus.sw_rst_req_i) begin
            state_nxt   = S_IDLE;
            idx_nxt     = '0;
            cnt_nxt     = '0;
            err_nxt     = 1'b0;
            err_dom_nxt = '0;
          end
        end
`endif
        S_GAP: begin
          if (bus.sw_rst_req_i) begin
            do_abort = 1'b1;
          end else if (cnt >= GAP_LAST) begin
            next_dom = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_DONE: begin
          if (bus.sw_rst_req_i) begin
            do_abort  = 1'b1;
            abort_idx = LAST;
            ready_nxt = 1'b0;
          end
        end
        S_ASSERT_SEQ: begin
          // dom[idx] is already low here; drop the next one down after the gap
          if (cnt >= GAP_C) begin
            dom_nxt = dom_q & ~(sel >> 1);
            cnt_nxt = '0;
            if (idx <= IW'(1)) begin
              state_nxt = S_IDLE;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx - IW'(1);
            end
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          dom_nxt   = '0;
        end
      endcase
    end

    // A zero gap skips the GAP state entirely so releases land on consecutive clocks
    if (adv) begin
      if (GAP_CYCLES == 0) begin
        next_dom = 1'b1;
      end else begin
        state_nxt = S_GAP;
        cnt_nxt   = '0;
      end
    end

    if (next_dom) begin
      cnt_nxt = '0;
      if (idx == LAST) begin
        state_nxt = S_DONE;
      end else begin
        idx_nxt   = idx + IW'(1);
        state_nxt = S_RELEASE;
      end
    end

    // Reverse sequence starts by dropping the current domain on this edge
    if (do_abort) begin
      abort_sel = NUM_DOMAINS'(1) << abort_idx;
      dom_nxt   = dom_q & ~abort_sel;
      cnt_nxt   = '0;
      if (abort_idx == '0) begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end else begin
        state_nxt = S_ASSERT_SEQ;
        idx_nxt   = abort_idx;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt       <= '0;
      dom_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      err_dom_q <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      dom_q     <= dom_nxt;
      ready_q   <= ready_nxt;
      busy_q    <= busy_nxt;
      err_q     <= err_nxt;
      err_dom_q <= err_dom_nxt;
    end
  end

  assign bus.dom_rst_n_o = dom_q;
  assign bus.all_ready_o = ready_q;
  assign bus.busy_o      = busy_q;
  assign bus.err_o       = err_q;
  assign bus.err_dom_o   = err_dom_q;

endmodule
